led_channel_array: RTL and testbench

//  Parametrised NUM_CH-channel LED driver, each channel a registered copy of the per-bit rule LED = ~VAL & enable.

---
 rtl/led_channel_array_pkg.sv | 18 +
 rtl/led_channel_array_if.sv | 23 ++
 rtl/led_channel_array_channel.sv | 63 ++++++
 rtl/led_channel_array.sv | 115 +++++++++++
 tb/tb_led_channel_array.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/led_channel_array_pkg.sv
// Shared types for the LED channel array: channel modes and config handshake states.
// No logic; latency and backpressure are defined by the modules that import it.
// Mode encodings are visible to software through the config port.
package led_array_pkg;

  typedef logic [1:0] led_mode_t;

  localparam led_mode_t MODE_OFF   = 2'd0;
  localparam led_mode_t MODE_DIR   = 2'd1;
  localparam led_mode_t MODE_BLINK = 2'd2;
  localparam led_mode_t MODE_PWM   = 2'd3;

  typedef enum logic {
    HS_IDLE = 1'b0,
    HS_BUSY = 1'b1
  } hs_state_t;

endpackage

// File: rtl/led_channel_array_if.sv
// Config write port for the LED channel array (valid/ready plus sticky error).
// Combinational bundle; no latency of its own.
// Master holds valid/ch/mode/duty until it sees ready.
interface led_channel_array_if
  import led_array_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int PWM_W  = 8
) ();

  localparam int CH_W = $clog2(NUM_CH) + 1;

  logic             valid;
  logic             ready;
  logic [CH_W-1:0]  ch;
  led_mode_t        mode;
  logic [PWM_W-1:0] duty;
  logic             err;

  modport master (output valid, ch, mode, duty, input ready, err);
  modport slave  (input valid, ch, mode, duty, output ready, err);

endinterface

// File: rtl/led_channel_array_channel.sv
// One LED channel: mode register, shadow/active PWM duty, registered LED output.
// LED is one cycle after val; a mode write shows on LED one cycle after it lands.
// No backpressure; the write strobe is a single-cycle pulse from the top.
module led_channel
  import led_array_pkg::*;
#(
  parameter int        PWM_W    = 8,
  parameter led_mode_t DEF_MODE = MODE_DIR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wrap,
  input  logic             blink,
  input  logic [PWM_W-1:0] pwm_cnt,
  input  logic             val,
  input  logic             we,
  input  led_mode_t        cfg_mode,
  input  logic [PWM_W-1:0] cfg_duty,
  output logic             led
);

  led_mode_t        mode;
  logic [PWM_W-1:0] duty_shadow;
  logic [PWM_W-1:0] duty_act;
  logic             led_nxt;

  // Active duty only changes on a period boundary so no PWM period is cut short.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode        <= DEF_MODE;
      duty_shadow <= '0;
      duty_act    <= '0;
    end else begin
      if (we) begin
        mode        <= cfg_mode;
        duty_shadow <= cfg_duty;
      end
      if (wrap) begin
        duty_act <= duty_shadow;
      end
    end
  end

  always_comb begin
    led_nxt = 1'b0;
    case (mode)
      MODE_OFF:   led_nxt = 1'b0;
      MODE_DIR:   led_nxt = ~val;
      MODE_BLINK: led_nxt = ~val & blink;
      MODE_PWM:   led_nxt = ~val & (pwm_cnt < duty_act);
      default:    led_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led <= 1'b0;
    end else begin
      led <= led_nxt;
    end
  end

endmodule

// File: rtl/led_channel_array.sv
// NUM_CH-channel LED driver with per-channel off/direct/blink/PWM mode and shared time base.
// LED is registered one cycle after val; config writes take effect on LED two cycles after accept.
// Config port accepts at most one write every two cycles (ready drops for one cycle after accept).
module led_channel_array
  import led_array_pkg::*;
#(
  parameter int        NUM_CH   = 4,
  parameter int        PWM_W    = 8,
  parameter int        PRESCALE = 16,
  parameter led_mode_t DEF_MODE = MODE_DIR
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_CH-1:0]   val,
  led_channel_array_if.slave  cfg,
  output logic [NUM_CH-1:0]   led
);

  localparam int                CH_W    = $clog2(NUM_CH) + 1;
  localparam int                PSC_W   = $clog2(PRESCALE + 1);
  localparam logic [PSC_W-1:0]  PSC_MAX = PSC_W'(PRESCALE - 1);

  logic [PSC_W-1:0] psc;
  logic [PWM_W-1:0] pwm_cnt;
  logic             blink;
  logic             tick;
  logic             wrap;

  hs_state_t        hs_state;
  hs_state_t        hs_state_nxt;
  logic             cfg_ready;
  logic             accept;
  logic             ch_bad;
  logic             err;
  logic [NUM_CH-1:0] we;

  // Shared time base keeps every channel's blink and PWM phase-aligned.
  assign tick = (psc == PSC_MAX);
  assign wrap = tick && (pwm_cnt == '1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psc     <= '0;
      pwm_cnt <= '0;
      blink   <= 1'b0;
    end else begin
      psc <= tick ? '0 : psc + 1'b1;
      if (tick) begin
        pwm_cnt <= pwm_cnt + 1'b1;
      end
      if (wrap) begin
        blink <= ~blink;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_state <= HS_IDLE;
    end else begin
      hs_state <= hs_state_nxt;
    end
  end

  always_comb begin
    hs_state_nxt = hs_state;
    case (hs_state)
      HS_IDLE: if (cfg.valid) hs_state_nxt = HS_BUSY;
      HS_BUSY: hs_state_nxt = HS_IDLE;
      default: hs_state_nxt = HS_IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = (hs_state == HS_IDLE);
  end

  assign accept    = cfg.valid && cfg_ready;
  assign ch_bad    = (cfg.ch >= CH_W'(NUM_CH));
  assign cfg.ready = cfg_ready;
  assign cfg.err   = err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (accept && ch_bad) begin
      err <= 1'b1;
    end
  end

  // Full-width index compare: out-of-range channels never alias onto a real one.
  always_comb begin
    we = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      we[i] = accept && (cfg.ch == CH_W'(i));
    end
  end

  led_channel #(
    .PWM_W    (PWM_W),
    .DEF_MODE (DEF_MODE)
  ) u_ch [NUM_CH-1:0] (
    .clk      (clk),
    .rst      (rst),
    .wrap     (wrap),
    .blink    (blink),
    .pwm_cnt  (pwm_cnt),
    .val      (val),
    .we       (we),
    .cfg_mode (cfg.mode),
    .cfg_duty (cfg.duty),
    .led      (led)
  );

endmodule

// File: tb/tb_led_channel_array.sv
// Directed bench for led_channel_array: NUM_CH=4, PWM_W=4, PRESCALE=4 (PWM period 64 cycles).
module tb_led_channel_array;

  localparam int PERIOD = 64;

  logic       clk;
  logic       rst;
  logic [3:0] val;
  logic [3:0] led;
  int         ecnt;
  int         total;
  int         bad;

  typedef struct {
    logic [3:0] val;
    logic [3:0] led;
  } vec_t;

  vec_t vecs [5];

  led_channel_array_if #(.NUM_CH(4), .PWM_W(4)) cfg ();

  led_channel_array #(
    .NUM_CH   (4),
    .PWM_W    (4),
    .PRESCALE (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .val (val),
    .cfg (cfg),
    .led (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since reset release; the time-base phase is derived from this.
  always @(posedge clk or posedge rst) begin
    if (rst) ecnt <= 0;
    else     ecnt <= ecnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // LED after edge m: ch3 direct, ch2 off, ch1 blink, ch0 PWM with the given duty; val=0.
  function automatic logic [3:0] exp_led(input int m, input int duty);
    logic p;
    logic b;
    p = (((m - 1) % PERIOD) / 4) < duty;
    b = (((m - 1) / PERIOD) % 2) == 1;
    return {1'b1, 1'b0, b, p};
  endfunction

  task automatic cfg_write(input logic [2:0] ch, input logic [1:0] md, input logic [3:0] dt);
    int t;
    t = 0;
    while (!cfg.ready && t < 8) begin
      @(posedge clk); #1;
      t++;
    end
    check("wr_ready_wait", 32'(cfg.ready), 32'd1);
    cfg.valid = 1'b1;
    cfg.ch    = ch;
    cfg.mode  = md;
    cfg.duty  = dt;
    @(posedge clk); #1;
    cfg.valid = 1'b0;
    check("wr_ready_drop", 32'(cfg.ready), 32'd0);
    @(posedge clk); #1;
    check("wr_ready_back", 32'(cfg.ready), 32'd1);
  endtask

  task automatic pwm_window(input string name, input int duty, input int wr_at, input logic [3:0] wr_duty);
    int highs;
    int mism;
    highs = 0;
    mism  = 0;
    for (int k = 0; k < PERIOD; k++) begin
      @(posedge clk); #1;
      if (led !== exp_led(ecnt, duty)) mism++;
      if (led[0] === 1'b1) highs++;
      if (k == wr_at) begin
        cfg.valid = 1'b1;
        cfg.ch    = 3'd0;
        cfg.mode  = 2'd3;
        cfg.duty  = wr_duty;
      end else begin
        cfg.valid = 1'b0;
      end
    end
    check({name, "_mism"}, 32'(mism), 32'd0);
    check({name, "_highs"}, 32'(highs), 32'(duty * 4));
  endtask

  initial begin
    int t;
    int mism;
    logic [3:0] prev;

    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    val       = 4'b1010;
    cfg.valid = 1'b0;
    cfg.ch    = '0;
    cfg.mode  = '0;
    cfg.duty  = '0;

    vecs[0] = '{val: 4'b1010, led: 4'b0101};
    vecs[1] = '{val: 4'b1111, led: 4'b0000};
    vecs[2] = '{val: 4'b0110, led: 4'b1001};
    vecs[3] = '{val: 4'b0001, led: 4'b1110};
    vecs[4] = '{val: 4'b0000, led: 4'b1111};

    #12;
    check("rst_led", 32'(led), 32'd0);
    check("rst_ready", 32'(cfg.ready), 32'd1);
    check("rst_err", 32'(cfg.err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Direct mode from reset: LED = ~val one cycle later, never combinational.
    prev = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      val = vecs[i].val;
      #2;
      check("dir_hold", 32'(led), 32'(prev));
      @(posedge clk); #1;
      check("dir_led", 32'(led), 32'(vecs[i].led));
      prev = vecs[i].led;
    end

    // ch2 off: ready dips one cycle, LED changes two cycles after accept.
    cfg.valid = 1'b1; cfg.ch = 3'd2; cfg.mode = 2'd0; cfg.duty = 4'd0;
    @(posedge clk); #1;
    cfg.valid = 1'b0;
    check("off_ready_drop", 32'(cfg.ready), 32'd0);
    check("off_led_early", 32'(led), 32'b1111);
    @(posedge clk); #1;
    check("off_ready_back", 32'(cfg.ready), 32'd1);
    check("off_led", 32'(led), 32'b1011);

    // Valid held through ready=0 with changed data must not cause a second write.
    cfg.valid = 1'b1; cfg.ch = 3'd3; cfg.mode = 2'd0;
    @(posedge clk); #1;
    cfg.ch = 3'd1;
    check("hold_ready_drop", 32'(cfg.ready), 32'd0);
    @(posedge clk); #1;
    cfg.valid = 1'b0;
    check("hold_ch3_off", 32'(led), 32'b0011);
    check("hold_ready_back", 32'(cfg.ready), 32'd1);
    @(posedge clk); #1;
    check("hold_no_effect", 32'(led), 32'b0011);

    cfg_write(3'd3, 2'd1, 4'd0);
    check("ch3_restore", 32'(led), 32'b1011);
    cfg_write(3'd1, 2'd2, 4'd0);
    check("blink_dark", 32'(led), 32'b1001);
    cfg_write(3'd0, 2'd3, 4'd4);
    check("pwm_duty0_off", 32'(led), 32'b1000);
    check("err_clean", 32'(cfg.err), 32'd0);

    t = 0;
    while ((ecnt % PERIOD) != 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check("wrap_align", 32'(ecnt % PERIOD), 32'd0);

    pwm_window("pwm4",   4, 20, 4'd12);
    pwm_window("pwm12", 12, 20, 4'd15);
    pwm_window("pwm15a", 15, 62, 4'd3);
    pwm_window("pwm15b", 15, -1, 4'd0);
    pwm_window("pwm3",   3, -1, 4'd0);

    // Out-of-range channels: handshake completes, sticky error, nothing else moves.
    cfg_write(3'd4, 2'd0, 4'd0);
    check("err_ch4", 32'(cfg.err), 32'd1);
    mism = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (led !== exp_led(ecnt, 3)) mism++;
    end
    check("err_ch4_led", 32'(mism), 32'd0);
    cfg_write(3'd5, 2'd0, 4'd0);
    mism = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (led !== exp_led(ecnt, 3)) mism++;
    end
    check("err_ch5_led", 32'(mism), 32'd0);
    check("err_sticky", 32'(cfg.err), 32'd1);

    // Asynchronous reset mid-PWM takes effect before the next edge.
    #2;
    rst = 1'b1;
    #1;
    check("arst_led", 32'(led), 32'd0);
    check("arst_ready", 32'(cfg.ready), 32'd1);
    check("arst_err", 32'(cfg.err), 32'd0);
    @(posedge clk); #1;
    val = 4'b1010;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_dir", 32'(led), 32'b0101);
    check("post_rst_err", 32'(cfg.err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
